// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  localparam int WORD_W      = 32;
  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_word_array.sv
// Single-port word RAM with registered read and no reset. rdata only moves on
// an enabled read, so it holds the last read word across writes and idle cycles.
module mem_word_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  // Write or read one word per enabled cycle; a write does not update rdata.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[idx] <= wdata;
      end else begin
        rdata <= mem_q[idx];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle responder for the MEM-stage data-memory port.
//
//  state | meaning
//  IDLE  | waiting; a request is captured and stall is raised this cycle
//  BUSY  | wait cycles counting down; RAM is accessed on the last one
//  RESP  | ready (and misalign) pulse; stall low so the pipeline advances
module data_mem_responder
  import mem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  parameter  int LATENCY     = 2,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  output logic        ready,
  output logic        stall,
  output logic        misalign
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be in 1..15");
  end
  if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("data_mem_responder: DEPTH_WORDS must be a power of two >= 4");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ready_q, ready_d;
  logic               misalign_q, misalign_d;
  logic               rd_valid_q;

  logic [AW-1:0]      idx_q;
  logic [1:0]         off_q;
  logic               we_q;
  logic [WORD_W-1:0]  wdata_q;

  logic               req;
  logic               acc_fire;
  logic [AW-1:0]      acc_idx;
  logic [1:0]         acc_off;
  logic               acc_we;
  logic [WORD_W-1:0]  acc_wdata;
  logic               ram_en;
  logic [WORD_W-1:0]  ram_rdata;
  logic               unused_addr_hi;

  // Only the word index and byte offset matter; higher address bits wrap away.
  assign unused_addr_hi = ^addr[31:AW+2];

  assign req   = re | we;
  assign stall = ((state_q == IDLE) && req) || (state_q == BUSY);

  // With LATENCY==1 the RAM is hit at the end of the accept cycle, before the
  // capture registers are loaded, so the live inputs feed the RAM in IDLE.
  assign acc_fire  = ((state_q == IDLE) && req && (LATENCY == 1)) ||
                     ((state_q == BUSY) && (count_q == CNT_W'(1)));
  assign acc_idx   = (state_q == IDLE) ? addr[AW+1:2] : idx_q;
  assign acc_off   = (state_q == IDLE) ? addr[1:0]    : off_q;
  assign acc_we    = (state_q == IDLE) ? we           : we_q;
  assign acc_wdata = (state_q == IDLE) ? datain       : wdata_q;

  // Gating with rst_n drops an access whose final wait cycle coincides with reset.
  assign ram_en = acc_fire && rst_n && (acc_off == 2'b00);

  // Until the first completed read the RAM read register is meaningless; show zero.
  assign dataout  = rd_valid_q ? ram_rdata : '0;
  assign ready    = ready_q;
  assign misalign = misalign_q;

  // Next-state and pulse decode for the request sequencer.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ready_d    = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          count_d = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d    = RESP;
            ready_d    = 1'b1;
            misalign_d = (addr[1:0] != 2'b00);
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        count_d = count_q - 1'b1;
        if (count_q == CNT_W'(1)) begin
          state_d    = RESP;
          ready_d    = 1'b1;
          misalign_d = (off_q != 2'b00);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, wait counter and registered response pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      ready_q    <= 1'b0;
      misalign_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      misalign_q <= misalign_d;
      if (ram_en && !acc_we) begin
        rd_valid_q <= 1'b1;
      end
    end
  end

  // Capture the request on acceptance; re&&we is handled as a plain write.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && req) begin
      idx_q   <= addr[AW+1:2];
      off_q   <= addr[1:0];
      we_q    <= we;
      wdata_q <= datain;
    end
  end

  mem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (acc_we),
    .idx  (acc_idx),
    .wdata(acc_wdata),
    .rdata(ram_rdata)
  );

endmodule
